pixel_fetch_unit: RTL and testbench



---
 rtl/pixel_fetch_unit.sv | 205 ++++++++++++++++++++
 tb/tb_pixel_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch_unit.sv
// pixel_fetch_unit: turns an (x, y, z) pixel request into SRAM row reads and
// streams back a burst of consecutive pixels, one per cycle, lane 0 at LSB.
// Flags out-of-range coordinates and SRAM timeouts with one-cycle pulses.
// Build option: define PIXEL_FETCH_ROW_CACHE_EN to keep the last fetched row
// and skip the SRAM read when the next request falls in that same row.
module pixel_fetch_unit #(
  parameter int PIXEL_BITS     = 4,
  parameter int MEM_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH     = 11,
  parameter int IMG_W          = 32,
  parameter int IMG_H          = 32,
  parameter int IMG_C          = 3,
  parameter int BASE_ADDR      = 0,
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 80
) (
  input  logic                             clock,
  input  logic                             rst,
  input  logic [31:0]                      x,
  input  logic [31:0]                      y,
  input  logic [31:0]                      z,
  input  logic [$clog2(MAX_BURST):0]       burst_len,
  input  logic                             trigger,
  input  logic                             mem_data_ready,
  input  logic [MEM_DATA_WIDTH-1:0]        mem_data_out,
  output logic                             mem_we,
  output logic                             mem_csb,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [PIXEL_BITS-1:0]            pix,
  output logic                             pix_valid,
  output logic                             pix_last,
  output logic                             busy,
  output logic                             err_range,
  output logic                             err_timeout
);

  localparam int PPR = MEM_DATA_WIDTH / PIXEL_BITS;
  localparam int LW  = (PPR > 1) ? $clog2(PPR) : 1;
  localparam int BLW = $clog2(MAX_BURST) + 1;
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] TOTAL = 32'(IMG_W * IMG_H * IMG_C);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]                state;
  logic                      trigger_prev;
  logic [ADDR_WIDTH-1:0]     row_addr;
  logic [LW-1:0]             lane;
  logic [BLW-1:0]            remain;
  logic [TW-1:0]             tcnt;
  logic [MEM_DATA_WIDTH-1:0] row_data;
`ifdef PIXEL_FETCH_ROW_CACHE_EN
  logic                      cache_vld;
  logic [ADDR_WIDTH-1:0]     cache_addr;
`endif

  logic [31:0]           idx_c;
  logic [31:0]           row_c;
  logic [31:0]           left_c;
  logic [LW-1:0]         lane_c;
  logic [BLW-1:0]        blen_c;
  logic [BLW-1:0]        rem_c;
  logic                  in_range_c;
  logic                  start_c;
  logic                  capture_c;
  logic [PIXEL_BITS-1:0] pix_c;

  // Request decode: linear index, row/lane split, clamped and image-clipped burst length.
  always_comb begin
    idx_c      = (z * 32'(IMG_H) + y) * 32'(IMG_W) + x;
    row_c      = idx_c / 32'(PPR);
    lane_c     = LW'(idx_c % 32'(PPR));
    if (burst_len == '0)
      blen_c = BLW'(1);
    else if (burst_len > BLW'(MAX_BURST))
      blen_c = BLW'(MAX_BURST);
    else
      blen_c = burst_len;
    left_c     = TOTAL - idx_c;
    rem_c      = (left_c < 32'(blen_c)) ? BLW'(left_c) : blen_c;
    in_range_c = (x < 32'(IMG_W)) && (y < 32'(IMG_H)) && (z < 32'(IMG_C));
    start_c    = trigger && !trigger_prev;
    capture_c  = (state == S_REQ) && !mem_csb && mem_data_ready;
  end

  // Lane select out of the held row using constant slices only.
  always_comb begin
    pix_c = '0;
    for (int k = 0; k < PPR; k++)
      if (lane == LW'(k)) pix_c = row_data[k*PIXEL_BITS +: PIXEL_BITS];
  end

  // Control FSM and all externally visible outputs.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      trigger_prev <= 1'b1;
      mem_csb      <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      pix          <= '0;
      pix_valid    <= 1'b0;
      pix_last     <= 1'b0;
      busy         <= 1'b0;
      err_range    <= 1'b0;
      err_timeout  <= 1'b0;
      row_addr     <= '0;
      lane         <= '0;
      remain       <= '0;
      tcnt         <= '0;
`ifdef PIXEL_FETCH_ROW_CACHE_EN
      cache_vld    <= 1'b0;
`endif
    end else begin
      trigger_prev <= trigger;
      pix_valid    <= 1'b0;
      pix_last     <= 1'b0;
      err_range    <= 1'b0;
      err_timeout  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_c) begin
            if (!in_range_c) begin
              err_range <= 1'b1;
            end else begin
              busy     <= 1'b1;
              state    <= S_REQ;
              row_addr <= ADDR_WIDTH'(32'(BASE_ADDR) + row_c);
              lane     <= lane_c;
              remain   <= rem_c;
            end
          end
        end
        S_REQ: begin
          if (mem_csb) begin
`ifdef PIXEL_FETCH_ROW_CACHE_EN
            if (cache_vld && (cache_addr == row_addr)) begin
              state <= S_OUT;
            end else begin
              mem_csb  <= 1'b0;
              mem_we   <= 1'b1;
              mem_addr <= row_addr;
              tcnt     <= '0;
            end
`else
            mem_csb  <= 1'b0;
            mem_we   <= 1'b1;
            mem_addr <= row_addr;
            tcnt     <= '0;
`endif
          end else if (mem_data_ready) begin
            mem_csb <= 1'b1;
            mem_we  <= 1'b0;
            state   <= S_OUT;
`ifdef PIXEL_FETCH_ROW_CACHE_EN
            cache_vld <= 1'b1;
`endif
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            mem_csb     <= 1'b1;
            mem_we      <= 1'b0;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
`ifdef PIXEL_FETCH_ROW_CACHE_EN
            cache_vld   <= 1'b0;
`endif
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_OUT: begin
          pix       <= pix_c;
          pix_valid <= 1'b1;
          remain    <= remain - 1'b1;
          lane      <= (lane == LW'(PPR - 1)) ? '0 : lane + 1'b1;
          if (remain == BLW'(1)) begin
            pix_last <= 1'b1;
            state    <= S_DONE;
          end else if (lane == LW'(PPR - 1)) begin
            row_addr <= row_addr + 1'b1;
            state    <= S_REQ;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Row capture (doubles as the cached row when caching is built in).
  always_ff @(posedge clock) begin
    if (capture_c) begin
      row_data <= mem_data_out;
`ifdef PIXEL_FETCH_ROW_CACHE_EN
      cache_addr <= mem_addr;
`endif
    end
  end

endmodule

// File: tb/tb_pixel_fetch_unit.sv
// tb_pixel_fetch_unit: vector table plus hand sequences for pixel_fetch_unit
// with an SRAM responder and expected-pixel / expected-address queues.
module tb_pixel_fetch_unit;

  logic        clock = 1'b0;
  logic        rst;
  logic [31:0] x, y, z;
  logic [4:0]  burst_len;
  logic        trigger;
  logic        mem_data_ready;
  logic [63:0] mem_data_out;
  logic        mem_we, mem_csb;
  logic [10:0] mem_addr;
  logic [3:0]  pix;
  logic        pix_valid, pix_last, busy, err_range, err_timeout;

  pixel_fetch_unit dut (
    .clock(clock), .rst(rst), .x(x), .y(y), .z(z), .burst_len(burst_len),
    .trigger(trigger), .mem_data_ready(mem_data_ready), .mem_data_out(mem_data_out),
    .mem_we(mem_we), .mem_csb(mem_csb), .mem_addr(mem_addr), .pix(pix),
    .pix_valid(pix_valid), .pix_last(pix_last), .busy(busy),
    .err_range(err_range), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         vx, vy, vz;
    logic [4:0] bl;
    int         lat;
    bit         err;
    logic [3:0] exp_first;
    int         exp_n;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int sram_lat = 2;
  logic [10:0] exp_addr_q[$];
  logic [4:0]  exp_pix_q[$];
  bit          mc_vld = 1'b0;
  logic [10:0] mc_addr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] row_val(input logic [10:0] a);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[k*4 +: 4] = 4'(15 - k) ^ a[3:0];
    return v;
  endfunction

  // Expected SRAM access, skipped when the bench's model of the row cache hits.
  task automatic push_addr(input logic [10:0] a);
`ifdef PIXEL_FETCH_ROW_CACHE_EN
    if (mc_vld && mc_addr == a) return;
    mc_vld  = 1'b1;
    mc_addr = a;
`endif
    exp_addr_q.push_back(a);
  endtask

  // SRAM responder: checks each new access address, answers after sram_lat cycles.
  initial begin
    int   cnt;
    logic prev_csb;
    cnt = 0; prev_csb = 1'b1;
    mem_data_ready = 1'b0; mem_data_out = '0;
    forever begin
      @(negedge clock);
      if (rst || mem_csb) begin
        mem_data_ready = 1'b0;
        cnt = 0;
      end else begin
        if (prev_csb) begin
          if (exp_addr_q.size() == 0) chk("unexpected_access", 64'(mem_addr), 64'h7FF_FFFF);
          else chk("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
        end
        cnt++;
        if (cnt >= sram_lat) begin
          mem_data_ready = 1'b1;
          mem_data_out   = row_val(mem_addr);
        end
      end
      prev_csb = mem_csb;
    end
  end

  task automatic run_vec(input vec_t v, input bit toggle);
    int idx, n, got, p;
    logic [4:0]  blc;
    logic [10:0] a;
    bit done, first;
    x = 32'(v.vx); y = 32'(v.vy); z = 32'(v.vz); burst_len = v.bl; sram_lat = v.lat;
    if (!v.err) begin
      idx = (v.vz * 32 + v.vy) * 32 + v.vx;
      blc = (v.bl == 0) ? 5'd1 : ((v.bl > 5'd16) ? 5'd16 : v.bl);
      n = (3072 - idx < int'(blc)) ? 3072 - idx : int'(blc);
      for (int i = 0; i < n; i++) begin
        p = idx + i;
        a = 11'(p / 16);
        if (i == 0 || p % 16 == 0) push_addr(a);
        exp_pix_q.push_back({(i == n - 1), 4'(15 - p % 16) ^ a[3:0]});
      end
    end
    @(negedge clock);
    trigger = 1'b1;
    if (v.err) begin
      @(negedge clock);
      chk("err_range_pulse", 64'(err_range), 64'd1);
      chk("err_range_busy", 64'(busy), 64'd0);
      chk("err_range_csb", 64'(mem_csb), 64'd1);
      @(negedge clock);
      chk("err_range_clear", 64'(err_range), 64'd0);
    end else begin
      got = 0; done = 1'b0; first = 1'b1;
      for (int c = 0; c < 400 && !done; c++) begin
        @(negedge clock);
        if (toggle && c == 3) trigger = 1'b0;
        if (toggle && c == 4) trigger = 1'b1;
        if (pix_valid) begin
          got++;
          if (first) chk("first_pix", 64'(pix), 64'(v.exp_first));
          first = 1'b0;
          if (exp_pix_q.size() == 0) chk("extra_pix", 64'({pix_last, pix}), 64'h7FF);
          else chk("pix", 64'({pix_last, pix}), 64'(exp_pix_q.pop_front()));
          if (pix_last) begin
            chk("busy_at_last", 64'(busy), 64'd1);
            @(negedge clock);
            chk("busy_after_last", 64'(busy), 64'd0);
            chk("valid_after_last", 64'(pix_valid), 64'd0);
            done = 1'b1;
          end
        end
      end
      if (!done) chk("burst_complete", 64'd0, 64'd1);
      chk("pix_count", 64'(got), 64'(v.exp_n));
      chk("addr_q_drained", 64'(exp_addr_q.size()), 64'd0);
      @(negedge clock);
      chk("no_restart", 64'(busy), 64'd0);
    end
    trigger = 1'b0;
    @(negedge clock);
  endtask

  vec_t vecs[10];

  initial begin
    int n;
    bit seen_pix, seen_err;
    vecs[0] = '{3, 2, 1, 5'd1, 2, 1'b0, 4'h8, 1};
    vecs[1] = '{14, 0, 0, 5'd4, 3, 1'b0, 4'h1, 4};
    vecs[2] = '{31, 31, 2, 5'd5, 1, 1'b0, 4'hF, 1};
    vecs[3] = '{28, 31, 2, 5'd16, 2, 1'b0, 4'hC, 4};
    vecs[4] = '{0, 1, 0, 5'd0, 2, 1'b0, 4'hD, 1};
    vecs[5] = '{0, 0, 1, 5'd31, 2, 1'b0, 4'hF, 16};
    vecs[6] = '{8, 0, 0, 5'd16, 4, 1'b0, 4'h7, 16};
    vecs[7] = '{32, 0, 0, 5'd1, 2, 1'b1, 4'h0, 0};
    vecs[8] = '{0, 32, 0, 5'd1, 2, 1'b1, 4'h0, 0};
    vecs[9] = '{0, 0, 3, 5'd1, 2, 1'b1, 4'h0, 0};

    rst = 1'b1; trigger = 1'b1; x = '0; y = '0; z = '0; burst_len = 5'd1;
    repeat (3) @(negedge clock);
    chk("rst_csb", 64'(mem_csb), 64'd1);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(pix_valid), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clock);
    chk("held_trigger_no_start", 64'({busy, mem_csb}), 64'b01);
    trigger = 1'b0;
    @(negedge clock);

    // Latency: x=5, SRAM answers 3 cycles after the request.
    x = 32'd5; sram_lat = 3;
    push_addr(11'd0);
    trigger = 1'b1;
    @(posedge clock); #1;
    chk("lat_T_busy_csb", 64'({busy, mem_csb}), 64'b11);
    @(posedge clock); #1;
    chk("lat_T1_req", 64'({mem_csb, mem_we, mem_addr}), {51'd0, 2'b01, 11'd0});
    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("lat_T3_wait", 64'({mem_csb, pix_valid}), 64'b00);
    @(posedge clock); #1;
    chk("lat_R_release", 64'({mem_csb, mem_we, pix_valid}), 64'b100);
    @(posedge clock); #1;
    chk("lat_R1_pix", 64'({pix_valid, pix_last, busy, pix}), {57'd0, 3'b111, 4'hA});
    @(posedge clock); #1;
    chk("lat_done", 64'({pix_valid, busy}), 64'b00);
    trigger = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], 1'b0);

    // Trigger re-edge mid-burst must be ignored.
    run_vec('{0, 0, 1, 5'd16, 3, 1'b0, 4'hF, 16}, 1'b1);

    // Timeout: SRAM never answers.
    x = 32'd0; y = 32'd5; z = 32'd0; burst_len = 5'd1; sram_lat = 100000;
    push_addr(11'd10);
    @(negedge clock);
    trigger = 1'b1;
    for (int c = 0; c < 10 && mem_csb; c++) @(negedge clock);
    chk("to_csb_low", 64'(mem_csb), 64'd0);
    n = 0; seen_pix = 1'b0; seen_err = 1'b0;
    for (int c = 0; c < 200 && !seen_err; c++) begin
      @(negedge clock);
      n++;
      if (pix_valid) seen_pix = 1'b1;
      if (err_timeout) seen_err = 1'b1;
    end
    chk("to_pulse_seen", 64'(seen_err), 64'd1);
    chk("to_cycles", 64'(n), 64'd80);
    chk("to_outputs", 64'({mem_csb, mem_we, busy}), 64'b100);
    chk("to_no_pix", 64'(seen_pix), 64'd0);
    mc_vld = 1'b0;
    @(negedge clock);
    chk("to_pulse_clear", 64'(err_timeout), 64'd0);
    trigger = 1'b0;
    run_vec('{0, 5, 0, 5'd1, 2, 1'b0, 4'hF ^ 4'hA, 1}, 1'b0);

    // Reset during an outstanding request.
    x = 32'd0; y = 32'd6; z = 32'd0; sram_lat = 100000;
    push_addr(11'd12);
    @(negedge clock);
    trigger = 1'b1;
    for (int c = 0; c < 10 && mem_csb; c++) @(negedge clock);
    chk("mid_req_csb_low", 64'(mem_csb), 64'd0);
    @(negedge clock);
    rst = 1'b1; #1;
    chk("mid_req_reset", 64'({mem_csb, mem_we, mem_addr, pix, pix_valid, pix_last, busy, err_range, err_timeout}),
        {42'd0, 2'b10, 11'd0, 4'h0, 5'b00000});
    mc_vld = 1'b0;
    @(negedge clock);
    rst = 1'b0; sram_lat = 2;
    repeat (4) @(negedge clock);
    chk("post_reset_idle", 64'({busy, mem_csb}), 64'b01);
    trigger = 1'b0;
    @(negedge clock);

    run_vec('{5, 0, 0, 5'd1, 2, 1'b0, 4'hA, 1}, 1'b0);
`ifdef PIXEL_FETCH_ROW_CACHE_EN
    // Same row again: served from the cache with no SRAM access.
    x = 32'd6; y = 32'd0; z = 32'd0; burst_len = 5'd1;
    trigger = 1'b1;
    @(posedge clock); #1;
    chk("hit_T", 64'({pix_valid, mem_csb}), 64'b01);
    @(posedge clock); #1;
    chk("hit_T1", 64'({pix_valid, mem_csb}), 64'b01);
    @(posedge clock); #1;
    chk("hit_T2_pix", 64'({pix_valid, pix_last, mem_csb, pix}), {57'd0, 3'b111, 4'h9});
    @(posedge clock); #1;
    chk("hit_done", 64'(busy), 64'd0);
    trigger = 1'b0;
    @(negedge clock);
`else
    run_vec('{6, 0, 0, 5'd1, 2, 1'b0, 4'h9, 1}, 1'b0);
`endif

    repeat (3) @(negedge clock);
    chk("end_queues", 64'(exp_addr_q.size() + exp_pix_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
